// File: rtl/pattern_detect_pkg.sv
// pattern_detect_pkg: shared FSM encoding, reset-default configuration and length clamp
package pattern_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [3:0] RST_PAT     = 4'b1010;
    localparam logic [3:0] RST_LEN     = 4'd4;
    localparam logic       RST_OVERLAP = 1'b1;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned w);
        return (len == 4'd0) ? 4'd1 : ({28'd0, len} > w) ? w[3:0] : len;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// pattern_match_core: serial history shift register, fill counter and masked pattern compare
module pattern_match_core #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             din_i,
    input  logic             overlap_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [3:0]       len_i,
    output logic             hit_o
);

    logic [PAT_W-1:0] hist_q, hist_d, mask;
    logic [3:0]       fill_q, fill_d;

    // window includes the incoming bit so a match is flagged in the same cycle
    always_comb begin
        hist_d = {hist_q[PAT_W-2:0], din_i};
        mask   = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_i));
        hit_o  = en_i && (fill_q >= len_i - 4'd1) && (((hist_d ^ pattern_i) & mask) == '0);
        fill_d = (hit_o && !overlap_i) ? 4'd0 : (fill_q >= len_i) ? len_i : fill_q + 4'd1;
    end

    // history and fill advance only on qualified bits; a clear wipes any partial match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (en_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: configurable serial pattern detector with run control and match counting
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_max,
    input  logic             start,
    input  logic             stop,
    input  logic             din_valid,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state
);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [3:0]       len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] max_q, count_q, count_p1, count_d;
    logic             run, cfg_acc, start_acc, done_hit;

    assign run         = (state_q == S_RUN);
    assign cfg_ready   = !run;
    assign cfg_acc     = cfg_valid && cfg_ready;
    assign start_acc   = start && cfg_ready && !cfg_valid;
    assign state       = state_q;
    assign match_count = count_q;

    // saturating increment; the wrapped value is used for the limit test so a saturated count never ends the run
    always_comb begin
        count_p1 = count_q + 1'b1;
        count_d  = (&count_q) ? count_q : count_p1;
        done_hit = match && (max_q != '0) && (count_p1 == max_q);
    end

    pattern_match_core #(.PAT_W(PAT_W)) u_core (
        .clk       (clk),
        .rst_n     (rst),
        .clr_i     (cfg_acc || start_acc),
        .en_i      (run && din_valid),
        .din_i     (din),
        .overlap_i (overlap_q),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .hit_o     (match)
    );

    // control FSM, match counter and latched configuration; a configuration offer outranks start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            pat_q     <= PAT_W'(RST_PAT);
            len_q     <= RST_LEN;
            overlap_q <= RST_OVERLAP;
            max_q     <= '0;
        end else if (cfg_acc) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            pat_q     <= cfg_pattern;
            len_q     <= clamp_len(cfg_len, PAT_W);
            overlap_q <= cfg_overlap;
            max_q     <= cfg_max;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (match) count_q <= count_d;
                    if (stop) state_q <= S_IDLE;
                    else if (done_hit) state_q <= S_DONE;
                end
                default: begin
                    if (start) begin
                        state_q <= S_RUN;
                        count_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// tb_pattern_detect_ctrl: directed self-checking bench for pattern_detect_ctrl
module tb_pattern_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0, cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_max = '0;
    logic       start = 1'b0, stop = 1'b0, din_valid = 1'b0, din = 1'b0;
    logic       match;
    logic [7:0] match_count;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_max     (cfg_max),
        .start       (start),
        .stop        (stop),
        .din_valid   (din_valid),
        .din         (din),
        .match       (match),
        .match_count (match_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] m);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_max = m;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp, input string tag);
        din_valid = 1'b1; din = b;
        #1 check(tag, 32'(match), 32'(exp));
        tick();
        din_valid = 1'b0;
    endtask

    task automatic gap(input logic b, input string tag);
        din_valid = 1'b0; din = b;
        #1 check(tag, 32'(match), 32'(1'b0));
        tick();
    endtask

    initial begin
        #12;
        check("rst_state", 32'(state), 32'(2'b00));
        check("rst_count", 32'(match_count), 32'(8'd0));
        check("rst_ready", 32'(cfg_ready), 32'(1'b1));
        check("rst_match", 32'(match), 32'(1'b0));
        rst = 1'b1;
        tick();

        // reset-default config 1010/len4/overlap
        do_start();
        check("run_state", 32'(state), 32'(2'b01));
        check("run_ready", 32'(cfg_ready), 32'(1'b0));
        send(1, 0, "ov_b1"); send(0, 0, "ov_b2"); send(1, 0, "ov_b3");
        send(0, 1, "ov_b4"); send(1, 0, "ov_b5"); send(0, 1, "ov_b6");
        check("ov_count", 32'(match_count), 32'(8'd2));
        din = 1'b1; din_valid = 1'b0;
        #1 check("novalid_match", 32'(match), 32'(1'b0));
        do_stop();
        check("stop_state", 32'(state), 32'(2'b00));
        check("stop_count_kept", 32'(match_count), 32'(8'd2));

        // non-overlapping detection
        do_cfg(8'b1010, 4'd4, 1'b0, 8'd0);
        check("cfg_clears_count", 32'(match_count), 32'(8'd0));
        do_start();
        send(1, 0, "no_b1"); send(0, 0, "no_b2"); send(1, 0, "no_b3");
        send(0, 1, "no_b4"); send(1, 0, "no_b5"); send(0, 0, "no_b6");
        check("no_count", 32'(match_count), 32'(8'd1));
        do_stop();

        // match limit reaches DONE
        do_cfg(8'b110, 4'd3, 1'b1, 8'd2);
        do_start();
        send(1, 0, "mx_b1"); send(1, 0, "mx_b2"); send(0, 1, "mx_b3");
        send(1, 0, "mx_b4"); send(1, 0, "mx_b5"); send(0, 1, "mx_b6");
        check("done_state", 32'(state), 32'(2'b10));
        check("done_count", 32'(match_count), 32'(8'd2));
        check("done_ready", 32'(cfg_ready), 32'(1'b1));
        send(1, 0, "done_b7"); send(1, 0, "done_b8"); send(0, 0, "done_b9");
        check("done_count_held", 32'(match_count), 32'(8'd2));

        // config and start together: config wins
        start = 1'b1;
        do_cfg(8'b0110, 4'd4, 1'b1, 8'd0);
        start = 1'b0;
        check("cfgstart_state", 32'(state), 32'(2'b00));
        check("cfgstart_count", 32'(match_count), 32'(8'd0));
        tick();
        check("cfgstart_still_idle", 32'(state), 32'(2'b00));

        // gaps carry opposite din values which must never shift in
        do_start();
        send(0, 0, "gp_b1"); gap(1, "gp_g1");
        send(1, 0, "gp_b2"); gap(0, "gp_g2"); gap(0, "gp_g3");
        send(1, 0, "gp_b3"); gap(0, "gp_g4");
        send(0, 1, "gp_b4");
        check("gp_count", 32'(match_count), 32'(8'd1));

        // stop coinciding with a match
        send(1, 0, "sm_b1"); send(1, 0, "sm_b2");
        stop = 1'b1;
        send(0, 1, "sm_match");
        stop = 1'b0;
        check("sm_state", 32'(state), 32'(2'b00));
        check("sm_count", 32'(match_count), 32'(8'd2));

        // reset mid-run after three of four bits
        do_start();
        send(0, 0, "rr_b1"); send(1, 0, "rr_b2"); send(1, 0, "rr_b3");
        din_valid = 1'b1; din = 1'b0;
        rst = 1'b0;
        #1;
        check("rr_state", 32'(state), 32'(2'b00));
        check("rr_count", 32'(match_count), 32'(8'd0));
        check("rr_match", 32'(match), 32'(1'b0));
        check("rr_ready", 32'(cfg_ready), 32'(1'b1));
        din_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        send(0, 0, "rr_final_idle");
        do_start();
        send(0, 0, "rr_final_run");
        send(1, 0, "rd_b1"); send(0, 0, "rd_b2"); send(1, 0, "rd_b3"); send(0, 1, "rd_b4");
        do_stop();

        // length clamps: 0 -> 1, 15 -> 8
        do_cfg(8'b1, 4'd0, 1'b1, 8'd0);
        do_start();
        send(1, 1, "len0_b1"); send(0, 0, "len0_b2");
        din_valid = 1'b1; din = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        din_valid = 1'b0;
        check("sat_count", 32'(match_count), 32'(8'hFF));
        check("sat_state", 32'(state), 32'(2'b01));
        do_stop();
        do_cfg(8'hA5, 4'd15, 1'b0, 8'd0);
        do_start();
        send(1, 0, "len15_b1"); send(0, 0, "len15_b2"); send(1, 0, "len15_b3"); send(0, 0, "len15_b4");
        send(0, 0, "len15_b5"); send(1, 0, "len15_b6"); send(0, 0, "len15_b7"); send(1, 1, "len15_b8");
        check("len15_count", 32'(match_count), 32'(8'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
